xy_frame_writer: RTL and testbench

- Writer side of the XY vector-display point stream.
- Accepts X/Y point pairs over a valid/ready handshake and writes them into a double-buffered point RAM.
- Exposes a registered read port, with the same 1-cycle latency as the image ROMs, for the DAC streamer.
- Bank swap is deferred to the reader's frame wrap, so a frame is never torn mid-draw.

---
 rtl/xy_stream_pkg.sv | 30 +++
 rtl/xy_point_ram.sv | 41 ++++
 rtl/xy_frame_writer.sv | 156 +++++++++++++++
 tb/tb_xy_frame_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xy_stream_pkg.sv
// Shared definitions for the XY vector-display point stream.
// Holds the default coordinate width and frame depth, the writer FSM states
// and the point word layout {blank (optional), x, y} stored in the point RAM.
// Optional feature macro: XY_BLANK_FLAG_EN adds a beam-blank bit to each point.
package xy_stream_pkg;

    localparam int unsigned XY_DATA_WIDTH = 9;
    localparam int unsigned XY_DEPTH      = 1231;

`ifdef XY_BLANK_FLAG_EN
    localparam int unsigned XY_BLANK_W = 1;
`else
    localparam int unsigned XY_BLANK_W = 0;
`endif

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } wr_state_e;

    // Point word at the default width; the RAM packs the same field order.
    typedef struct packed {
`ifdef XY_BLANK_FLAG_EN
        logic                     blank;
`endif
        logic [XY_DATA_WIDTH-1:0] x;
        logic [XY_DATA_WIDTH-1:0] y;
    } point_t;

endpackage

// File: rtl/xy_point_ram.sv
// Two-bank point RAM: one write port, one registered read port.
// Both ports take {bank, addr}; read data appears one cycle after the address.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data  write port
//   rd_addr / rd_data      read port, 1-cycle latency, resets to RD_RESET
module xy_point_ram #(
    parameter int unsigned        WORD_W     = 18,
    parameter int unsigned        ADDR_WIDTH = 11,
    parameter logic [WORD_W-1:0]  RD_RESET   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   wr_addr,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic [ADDR_WIDTH:0]   rd_addr,
    output logic [WORD_W-1:0]     rd_data
);

    localparam int unsigned N_WORDS = 1 << (ADDR_WIDTH + 1);

    logic [WORD_W-1:0] mem [N_WORDS];

    // Storage array is not reset; contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read, matching the image ROM latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data <= RD_RESET;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/xy_frame_writer.sv
// Writer side of the XY point stream: accepts X/Y beats over valid/ready and
// fills the inactive bank of a double-buffered point RAM. The bank swap waits
// for the reader's frame wrap (or happens at once if nothing is shown yet).
// Optional feature macro: XY_BLANK_FLAG_EN (adds i_blank / o_rd_blank).
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_valid/o_ready           beat handshake; i_x, i_y, i_last beat payload
//   i_rd_addr, i_rd_wrap      reader address into active bank, end-of-frame pulse
//   o_rd_x, o_rd_y            active-bank point, 1-cycle latency
//   o_frame_len               point count of the active frame
//   o_swap                    one-cycle pulse on bank swap
//   o_overflow                sticky: a frame was truncated at DEPTH points
//   i_blank, o_rd_blank       (XY_BLANK_FLAG_EN only) beam-blank bit per point
module xy_frame_writer
    import xy_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XY_DATA_WIDTH,
    parameter int unsigned DEPTH      = XY_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_y,
    input  logic                  i_last,
`ifdef XY_BLANK_FLAG_EN
    input  logic                  i_blank,
    output logic                  o_rd_blank,
`endif
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_rd_wrap,
    output logic [DATA_WIDTH-1:0] o_rd_x,
    output logic [DATA_WIDTH-1:0] o_rd_y,
    output logic [ADDR_WIDTH:0]   o_frame_len,
    output logic                  o_swap,
    output logic                  o_overflow
);

    localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
    localparam int unsigned WORD_W = 2 * DATA_WIDTH + XY_BLANK_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // Read register resets to zero coordinates with the blank bit (if any) set.
    localparam logic [WORD_W-1:0] RD_RESET = WORD_W'(XY_BLANK_W) << (2 * DATA_WIDTH);

    wr_state_e             state_q, state_d;
    logic                  bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]      pending_q, pending_d;
    logic [LEN_W-1:0]      frame_len_q, frame_len_d;
    logic                  ready_q, ready_d;
    logic                  swap_q, swap_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_en_c;
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W-1:0]     rd_word;

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= FILL;
            bank_q      <= 1'b0;
            wr_addr_q   <= '0;
            pending_q   <= '0;
            frame_len_q <= '0;
            ready_q     <= 1'b0;
            swap_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            wr_addr_q   <= wr_addr_d;
            pending_q   <= pending_d;
            frame_len_q <= frame_len_d;
            ready_q     <= ready_d;
            swap_q      <= swap_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state logic: fill the write bank, then wait for the reader's wrap.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        wr_addr_d   = wr_addr_q;
        pending_d   = pending_q;
        frame_len_d = frame_len_q;
        swap_d      = 1'b0;
        ovf_d       = ovf_q;
        wr_en_c     = 1'b0;

        case (state_q)
            FILL: begin
                // ready_q is low in the first cycle after reset, so it gates acceptance.
                if (i_valid && ready_q) begin
                    wr_en_c   = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                    // A full bank closes the frame even without i_last.
                    if (i_last || (wr_addr_q == LAST_ADDR)) begin
                        pending_d = LEN_W'(wr_addr_q) + LEN_W'(1);
                        state_d   = WAIT_SWAP;
                        if (!i_last) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_SWAP: begin
                // An empty display swaps straight away.
                if (i_rd_wrap || (frame_len_q == '0)) begin
                    bank_d      = ~bank_q;
                    frame_len_d = pending_q;
                    swap_d      = 1'b1;
                    wr_addr_d   = '0;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        ready_d = (state_d == FILL);
    end

`ifdef XY_BLANK_FLAG_EN
    assign wr_word    = {i_blank, i_x, i_y};
    assign o_rd_blank = rd_word[WORD_W-1];
`else
    assign wr_word    = {i_x, i_y};
`endif

    // Writes go to the inactive bank; reads sample the active bank with the address.
    xy_point_ram #(
        .WORD_W     (WORD_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_RESET   (RD_RESET)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_en   (wr_en_c),
        .wr_addr ({~bank_q, wr_addr_q}),
        .wr_data (wr_word),
        .rd_addr ({bank_q, i_rd_addr}),
        .rd_data (rd_word)
    );

    assign o_ready     = ready_q;
    assign o_swap      = swap_q;
    assign o_overflow  = ovf_q;
    assign o_frame_len = frame_len_q;
    assign o_rd_x      = rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
    assign o_rd_y      = rd_word[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_xy_frame_writer.sv
// Self-checking bench for xy_frame_writer: a per-bank point model predicts
// read data, expected reads are queued when addresses are driven and popped
// when the registered read data arrives.
`timescale 1ns/1ps
module tb_xy_frame_writer;

    localparam int unsigned DW    = 9;
    localparam int unsigned DEPTH = 1231;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          i_clk     = 1'b0;
    logic          i_rst_n   = 1'b0;
    logic          i_valid   = 1'b0;
    logic          i_last    = 1'b0;
    logic          i_rd_wrap = 1'b0;
    logic [DW-1:0] i_x       = '0;
    logic [DW-1:0] i_y       = '0;
    logic [AW-1:0] i_rd_addr = '0;
    logic          o_ready;
    logic          o_swap;
    logic          o_overflow;
    logic [DW-1:0] o_rd_x;
    logic [DW-1:0] o_rd_y;
    logic [AW:0]   o_frame_len;
`ifdef XY_BLANK_FLAG_EN
    logic          i_blank   = 1'b0;
    logic          o_rd_blank;
    logic          cur_blank = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    xy_frame_writer dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_last      (i_last),
`ifdef XY_BLANK_FLAG_EN
        .i_blank     (i_blank),
        .o_rd_blank  (o_rd_blank),
`endif
        .i_rd_addr   (i_rd_addr),
        .i_rd_wrap   (i_rd_wrap),
        .o_rd_x      (o_rd_x),
        .o_rd_y      (o_rd_y),
        .o_frame_len (o_frame_len),
        .o_swap      (o_swap),
        .o_overflow  (o_overflow)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned b;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int unsigned addr;
        int unsigned ex;
        int unsigned ey;
        int unsigned eb;
    } rd_vec_t;
    rd_vec_t vec[4];

    // Bench model of the two banks and the writer position.
    int unsigned mx [2][DEPTH];
    int unsigned my [2][DEPTH];
    int unsigned mb [2][DEPTH];
    int          model_active = 0;
    int          model_waddr  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endfunction

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic send_beat(int unsigned x, int unsigned y, bit last, bit wrap);
        int n = 0;
        i_valid = 1'b1;
        i_x     = DW'(x);
        i_y     = DW'(y);
        i_last  = last;
`ifdef XY_BLANK_FLAG_EN
        i_blank = cur_blank;
`endif
        while (o_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (o_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got o_ready=%b, want 1", o_ready);
        end else begin
            i_rd_wrap = wrap;
            mx[1-model_active][model_waddr] = x;
            my[1-model_active][model_waddr] = y;
`ifdef XY_BLANK_FLAG_EN
            mb[1-model_active][model_waddr] = 32'(cur_blank);
`endif
            model_waddr++;
            step();
        end
        i_valid   = 1'b0;
        i_last    = 1'b0;
        i_rd_wrap = 1'b0;
    endtask

    task automatic wait_swap(int max_cyc, output int lat);
        lat = 0;
        while (o_swap !== 1'b1 && lat < max_cyc) begin
            step();
            lat++;
        end
        if (o_swap !== 1'b1) lat = -1;
    endtask

    task automatic model_swap();
        model_active = 1 - model_active;
        model_waddr  = 0;
    endtask

    task automatic pulse_wrap(int unsigned exp_len);
        i_rd_wrap = 1'b1;
        step();
        i_rd_wrap = 1'b0;
        chk("wrap_swap", 32'(o_swap), 1);
        chk("wrap_frame_len", 32'(o_frame_len), exp_len);
        model_swap();
    endtask

    // Drive a read address, queue its expectation, compare one cycle later.
    task automatic rd_issue(int unsigned a, int unsigned ex, int unsigned ey, int unsigned eb);
        exp_t e;
        i_rd_addr = AW'(a);
        sb.push_back('{ex, ey, eb});
        step();
        e = sb.pop_front();
        chk("rd_x", 32'(o_rd_x), e.x);
        chk("rd_y", 32'(o_rd_y), e.y);
`ifdef XY_BLANK_FLAG_EN
        chk("rd_blank", 32'(o_rd_blank), e.b);
`endif
    endtask

    task automatic rd_model(int unsigned a);
        rd_issue(a, mx[model_active][a], my[model_active][a], mb[model_active][a]);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_ready"},     32'(o_ready), 0);
        chk({tag, "_frame_len"}, 32'(o_frame_len), 0);
        chk({tag, "_swap"},      32'(o_swap), 0);
        chk({tag, "_overflow"},  32'(o_overflow), 0);
        chk({tag, "_rd_x"},      32'(o_rd_x), 0);
        chk({tag, "_rd_y"},      32'(o_rd_y), 0);
`ifdef XY_BLANK_FLAG_EN
        chk({tag, "_rd_blank"},  32'(o_rd_blank), 1);
`endif
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vec[0] = '{2, 3, 30, 1};
        vec[1] = '{0, 1, 10, 1};
        vec[2] = '{3, 4, 40, 0};
        vec[3] = '{1, 2, 20, 0};

        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < int'(DEPTH); a++) begin
                mb[b][a] = 0;
            end
        end

        // Reset state
        @(negedge i_clk);
        repeat (2) step();
        chk_reset_outputs("reset");
        i_rst_n = 1'b1;
        step();
        chk("ready_after_reset", 32'(o_ready), 1);

        // Frame 1: four points, auto swap since nothing shown yet
        for (int i = 0; i < 4; i++) begin
`ifdef XY_BLANK_FLAG_EN
            cur_blank = (i % 2 == 0);
`endif
            send_beat(i + 1, (i + 1) * 10, i == 3, 1'b0);
        end
        chk("f1_ready_low", 32'(o_ready), 0);
        wait_swap(10, lat);
        chk("f1_swap_latency", 32'(lat), 1);
        chk("f1_frame_len", 32'(o_frame_len), 4);
        model_swap();
        step();
        chk("f1_swap_one_shot", 32'(o_swap), 0);
        for (int i = 0; i < 4; i++) begin
            rd_issue(vec[i].addr, vec[i].ex, vec[i].ey, vec[i].eb);
        end

        // Frame 2: held off until the reader wraps
`ifdef XY_BLANK_FLAG_EN
        cur_blank = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            send_beat(100 + i, 200 + i, i == 2, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            chk("f2_stall_ready", 32'(o_ready), 0);
            chk("f2_stall_swap", 32'(o_swap), 0);
            step();
        end
        chk("f2_old_len", 32'(o_frame_len), 4);
        rd_issue(1, 2, 20, 0);
        pulse_wrap(3);
        for (int i = 0; i < 3; i++) rd_model(i);

        // Wrap coincident with the accepting last beat does not swap
        send_beat(50, 60, 1'b0, 1'b0);
        send_beat(51, 61, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("coinc_no_swap", 32'(o_swap), 0);
            step();
        end
        chk("coinc_old_len", 32'(o_frame_len), 3);
        pulse_wrap(2);
        rd_model(0);
        rd_model(1);

        // Overflow: DEPTH beats with no last
        chk("ovf_clear_before", 32'(o_overflow), 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            send_beat(i % 512, (i * 7) % 512, 1'b0, 1'b0);
        end
        chk("ovf_ready_low", 32'(o_ready), 0);
        chk("ovf_set", 32'(o_overflow), 1);
        chk("ovf_old_len", 32'(o_frame_len), 2);
        pulse_wrap(DEPTH);
        rd_model(0);
        rd_model(617);
        rd_model(DEPTH - 1);
        send_beat(5, 6, 1'b0, 1'b0);
        send_beat(7, 8, 1'b1, 1'b0);
        pulse_wrap(2);
        chk("ovf_sticky", 32'(o_overflow), 1);
        rd_model(1);

        // Reset mid-frame, then a one-point frame
        send_beat(90, 91, 1'b0, 1'b0);
        send_beat(92, 93, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_active = 0;
        model_waddr  = 0;
        step();
        chk("midrst_ready_after", 32'(o_ready), 1);
        send_beat(17, 18, 1'b1, 1'b0);
        wait_swap(10, lat);
        chk("one_pt_swap_latency", 32'(lat), 1);
        chk("one_pt_frame_len", 32'(o_frame_len), 1);
        chk("one_pt_overflow", 32'(o_overflow), 0);
        model_swap();
        rd_model(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
